// File: rtl/pong_match_ctrl.sv
// rtl/pong_match_ctrl.sv - Pong match sequencer: serve, rally, pause, scoring, win detection
module pong_match_ctrl #(
  parameter int WIN_SCORE   = 9,
  parameter int SERVE_DELAY = 60,
  parameter int POINT_DELAY = 40
) (
  input  logic       dyn_clk,
  input  logic       reset,
  input  logic       play,
  input  logic       goal_ply1,
  input  logic       goal_ply2,
  output logic       ball_reset,
  output logic       ball_run,
  output logic       reset_goals,
  output logic [3:0] score_ply1,
  output logic [3:0] score_ply2,
  output logic [1:0] winner,
  output logic [2:0] state_code
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SERVE    = 3'd1,
    RALLY    = 3'd2,
    POINT    = 3'd3,
    PAUSE    = 3'd4,
    GAMEOVER = 3'd5
  } state_t;

  // Timer reload values are one less than the dwell because the load tick counts.
  localparam logic [7:0] SERVE_LOAD = 8'(SERVE_DELAY - 1);
  localparam logic [7:0] POINT_LOAD = 8'(POINT_DELAY - 1);
  localparam logic [3:0] WIN        = 4'(WIN_SCORE);

  state_t     state;
  logic [7:0] timer;
  logic       play_q;
  logic       play_rise;

  assign play_rise  = play & ~play_q;
  assign state_code = state;

  // Match state machine; every output is a register updated here.
  always_ff @(posedge dyn_clk) begin
    if (reset) begin
      state       <= IDLE;
      score_ply1  <= 4'd0;
      score_ply2  <= 4'd0;
      winner      <= 2'd0;
      ball_run    <= 1'b0;
      ball_reset  <= 1'b1;
      reset_goals <= 1'b0;
      timer       <= 8'd0;
      play_q      <= 1'b0;
    end else begin
      play_q      <= play;
      ball_reset  <= 1'b0;
      reset_goals <= 1'b0;
      ball_run    <= 1'b0;
      case (state)
        IDLE, GAMEOVER: begin
          if (play_rise) begin
            score_ply1  <= 4'd0;
            score_ply2  <= 4'd0;
            winner      <= 2'd0;
            reset_goals <= 1'b1;
            ball_reset  <= 1'b1;
            timer       <= SERVE_LOAD;
            state       <= SERVE;
          end
        end
        SERVE: begin
          if (timer == 8'd0) begin
            state    <= RALLY;
            ball_run <= 1'b1;
          end else begin
            timer <= timer - 8'd1;
          end
        end
        RALLY: begin
          // A goal always takes priority over a pause request in the same tick.
          if (goal_ply1 && goal_ply2) begin
            ball_reset <= 1'b1;
            timer      <= SERVE_LOAD;
            state      <= SERVE;
          end else if (goal_ply1) begin
            if (score_ply1 != 4'd15) score_ply1 <= score_ply1 + 4'd1;
            timer <= POINT_LOAD;
            state <= POINT;
          end else if (goal_ply2) begin
            if (score_ply2 != 4'd15) score_ply2 <= score_ply2 + 4'd1;
            timer <= POINT_LOAD;
            state <= POINT;
          end else if (play_rise) begin
            state <= PAUSE;
          end else begin
            ball_run <= 1'b1;
          end
        end
        POINT: begin
          if (timer == 8'd0) begin
            if (score_ply1 >= WIN) begin
              winner <= 2'd1;
              state  <= GAMEOVER;
            end else if (score_ply2 >= WIN) begin
              winner <= 2'd2;
              state  <= GAMEOVER;
            end else begin
              ball_reset <= 1'b1;
              timer      <= SERVE_LOAD;
              state      <= SERVE;
            end
          end else begin
            timer <= timer - 8'd1;
          end
        end
        PAUSE: begin
          if (play_rise) begin
            ball_run <= 1'b1;
            state    <= RALLY;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pong_match_ctrl.sv
// tb/tb_pong_match_ctrl.sv - randomized scoreboard bench for pong_match_ctrl
module tb_pong_match_ctrl;

  localparam int W  = 2;
  localparam int SD = 60;
  localparam int PD = 40;

  localparam int P_IDLE = 0, P_SERVE = 1, P_RALLY = 2, P_POINT = 3, P_PAUSE = 4, P_OVER = 5;

  logic       clk = 1'b0;
  logic       reset, play, goal_ply1, goal_ply2;
  logic       ball_reset, ball_run, reset_goals;
  logic [3:0] score_ply1, score_ply2;
  logic [1:0] winner;
  logic [2:0] state_code;

  always #5 clk = ~clk;

  pong_match_ctrl #(.WIN_SCORE(W), .SERVE_DELAY(SD), .POINT_DELAY(PD)) dut (
    .dyn_clk    (clk),
    .reset      (reset),
    .play       (play),
    .goal_ply1  (goal_ply1),
    .goal_ply2  (goal_ply2),
    .ball_reset (ball_reset),
    .ball_run   (ball_run),
    .reset_goals(reset_goals),
    .score_ply1 (score_ply1),
    .score_ply2 (score_ply2),
    .winner     (winner),
    .state_code (state_code)
  );

  logic [15:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  // Reference model: phase plus an absolute tick deadline for timed phases.
  int now = 0;
  int m_ph = P_IDLE, m_until = 0, m_s1 = 0, m_s2 = 0, m_win = 0;
  bit m_pq = 0, m_run = 0, m_brst = 0, m_rg = 0;

  task automatic start_serve();
    m_ph    = P_SERVE;
    m_brst  = 1;
    m_until = now + SD;
  endtask

  task automatic drive(input bit r, input bit p, input bit a, input bit b);
    bit rise;
    reset = r; play = p; goal_ply1 = a; goal_ply2 = b;
    now++;
    if (r) begin
      m_ph = P_IDLE; m_s1 = 0; m_s2 = 0; m_win = 0;
      m_brst = 1; m_rg = 0; m_pq = 0;
    end else begin
      rise = p && !m_pq;
      m_pq = p;
      m_brst = 0;
      m_rg = 0;
      case (m_ph)
        P_IDLE, P_OVER: if (rise) begin
          m_s1 = 0; m_s2 = 0; m_win = 0; m_rg = 1;
          start_serve();
        end
        P_SERVE: if (now == m_until) m_ph = P_RALLY;
        P_RALLY: begin
          if (a && b) start_serve();
          else if (a || b) begin
            if (a) m_s1 = (m_s1 + 1 > 15) ? 15 : m_s1 + 1;
            else   m_s2 = (m_s2 + 1 > 15) ? 15 : m_s2 + 1;
            m_ph = P_POINT;
            m_until = now + PD;
          end else if (rise) m_ph = P_PAUSE;
        end
        P_POINT: if (now == m_until) begin
          if (m_s1 >= W)      begin m_win = 1; m_ph = P_OVER; end
          else if (m_s2 >= W) begin m_win = 2; m_ph = P_OVER; end
          else start_serve();
        end
        P_PAUSE: if (rise) m_ph = P_RALLY;
        default: m_ph = P_IDLE;
      endcase
    end
    m_run = (m_ph == P_RALLY);
    exp_q.push_back({3'(m_ph), 4'(m_s1), 4'(m_s2), 2'(m_win), m_run, m_brst, m_rg});
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops one expected output vector per tick and compares it away from the edge.
  initial begin
    logic [15:0] exp_v, got_v;
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        got_v = {state_code, score_ply1, score_ply2, winner, ball_run, ball_reset, reset_goals};
        checks++;
        if (got_v !== exp_v) begin
          errors++;
          if (errors <= 30)
            $display("FAIL outputs t=%0t: got st=%0d s1=%0d s2=%0d win=%0d run=%b brst=%b rg=%b, required st=%0d s1=%0d s2=%0d win=%0d run=%b brst=%b rg=%b",
                     $time, got_v[15:13], got_v[12:9], got_v[8:5], got_v[4:3], got_v[2], got_v[1], got_v[0],
                     exp_v[15:13], exp_v[12:9], exp_v[8:5], exp_v[4:3], exp_v[2], exp_v[1], exp_v[0]);
        end
      end
    end
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL timeout: simulation did not finish, %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    bit p, a, b, r;
    p = 0;
    for (int i = 0; i < 3; i++) drive(1, 0, 0, 0);
    checks++;
    if (state_code !== 3'd0 || score_ply1 !== 4'd0 || score_ply2 !== 4'd0 || winner !== 2'd0 ||
        ball_run !== 1'b0 || ball_reset !== 1'b1 || reset_goals !== 1'b0) begin
      errors++;
      $display("FAIL reset state t=%0t: st=%0d s1=%0d s2=%0d win=%0d run=%b brst=%b rg=%b",
               $time, state_code, score_ply1, score_ply2, winner, ball_run, ball_reset, reset_goals);
    end
    drive(0, 0, 0, 0);
    drive(0, 1, 0, 0);
    for (int i = 0; i < 70; i++) drive(0, 0, 0, 0);
    checks++;
    if (state_code !== 3'd2 || ball_run !== 1'b1) begin
      errors++;
      $display("FAIL serve wait expired t=%0t: st=%0d run=%b, required st=2 run=1",
               $time, state_code, ball_run);
    end
    drive(0, 0, 1, 1);
    for (int i = 0; i < 65; i++) drive(0, 0, 0, 0);
    for (int i = 0; i < 20000; i++) begin
      r = ($urandom_range(0, 1499) == 0);
      if ($urandom_range(0, 7) == 0) p = !p;
      a = ($urandom_range(0, 24) == 0);
      b = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 149) == 0) begin a = 1; b = 1; end
      drive(r, p, a, b);
    end
    drive(0, 0, 0, 0);
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
